// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder: wait-state limit,
// FSM encoding, stall levels and the latched request record.
package data_sram_responder_pkg;

  localparam int DATA_SRAM_WAIT_MAX = 15;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    DSR_IDLE = 1'b0,
    DSR_BUSY = 1'b1
  } dsr_state_e;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dsr_req_t;

  // True when no address bit above the word index is set.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/data_sram_responder_bytelane.sv
// Word-organised storage with four independent byte write enables and a
// registered read port; contents are never reset.
module data_ram_bytelane #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: storage arrays carry no reset branch; resetting them would turn the
  // array into thousands of flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM interface: optional wait states with a
// pipeline stall request, range check, request latch and error pulse.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        access_err
);

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  dsr_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dsr_req_t    req_q, live_req, acc;
  logic        take, do_acc, in_rng, is_read;
  logic        rdata_zero_q;
  logic [31:0] ram_q;

  assign live_req = '{wen: data_sram_wen, addr: data_sram_addr, wdata: data_sram_wdata};

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    stallreq_for_mem = NO_STOP;
    take             = 1'b0;
    do_acc           = 1'b0;
    acc              = req_q;
    if (ZERO_WAIT) begin
      acc    = live_req;
      do_acc = data_sram_en;
    end else begin
      unique case (state_q)
        DSR_IDLE: begin
          if (data_sram_en) begin
            take             = 1'b1;
            cnt_d            = WAIT_INIT;
            state_d          = DSR_BUSY;
            stallreq_for_mem = STOP;
          end
        end
        DSR_BUSY: begin
          cnt_d            = cnt_q - 4'd1;
          stallreq_for_mem = (cnt_q > 4'd1) ? STOP : NO_STOP;
          if (cnt_q == 4'd1) begin
            do_acc  = 1'b1;
            state_d = DSR_IDLE;
          end
        end
        default: state_d = DSR_IDLE;
      endcase
    end
    // The RAM has no reset of its own, so a reset cycle must never reach it.
    if (rst) begin
      do_acc           = 1'b0;
      stallreq_for_mem = NO_STOP;
    end
  end

  assign in_rng  = addr_in_range(acc.addr, ADDR_W);
  assign is_read = (acc.wen == 4'b0000);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DSR_IDLE;
      cnt_q        <= 4'd0;
      rdata_zero_q <= 1'b1;
      access_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      access_err <= do_acc && !in_rng;
      if (do_acc && is_read) rdata_zero_q <= !in_rng;
    end
  end

  // Request latch needs no reset: it is only consumed after being loaded.
  always_ff @(posedge clk) begin
    if (take) req_q <= live_req;
  end

  data_ram_bytelane #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (do_acc && in_rng),
    .wen   (acc.wen),
    .rd_en (do_acc && in_rng && is_read),
    .addr  (acc.addr[ADDR_W+1:2]),
    .wdata (acc.wdata),
    .rdata (ram_q)
  );

  // Zero after reset or an out-of-range read; otherwise the RAM's read register.
  assign data_sram_rdata = rdata_zero_q ? 32'd0 : ram_q;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^acc.addr[1:0];

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responders (0, 2 and 3 wait states) sharing one
// request bus, directed vectors, a reset-in-BUSY sequence and random traffic.
module tb_data_sram_responder;

  localparam int ADDR_W = 12;
  localparam int NDUT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  int          sel;

  logic        en_v [NDUT];
  logic [31:0] rd   [NDUT];
  logic        st   [NDUT];
  logic        er   [NDUT];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NDUT; i++) en_v[i] = en && (sel == i);
  end

  data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .data_sram_en(en_v[0]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd[0]),
    .stallreq_for_mem(st[0]), .access_err(er[0]));

  data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .data_sram_en(en_v[1]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd[1]),
    .stallreq_for_mem(st[1]), .access_err(er[1]));

  data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .data_sram_en(en_v[2]), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rd[2]),
    .stallreq_for_mem(st[2]), .access_err(er[2]));

  function automatic int wait_of(input int s);
    case (s)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance word store and the last visible read data.
  logic [31:0] mem_m [NDUT][2**ADDR_W];
  logic [31:0] rd_m  [NDUT];

  task automatic model_access(input int s, input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] exp_rd,
                              output logic exp_err);
    int idx;
    exp_err = (a >= (32'd4 << ADDR_W));
    idx     = int'(a[ADDR_W+1:2]);
    if (exp_err) begin
      if (w == 4'b0000) rd_m[s] = 32'd0;
    end else if (w == 4'b0000) begin
      rd_m[s] = mem_m[s][idx];
    end else begin
      for (int b = 0; b < 4; b++)
        if (w[b]) mem_m[s][idx][8*b +: 8] = d[8*b +: 8];
    end
    exp_rd = rd_m[s];
  endtask

  logic        pend = 1'b0;
  int          pend_sel;
  logic [31:0] pend_rd;
  logic        pend_err;

  // Called on a falling edge: checks the result of the previous access.
  task automatic check_pending();
    for (int i = 0; i < NDUT; i++)
      check("access_err", 32'(er[i]), 32'((pend && i == pend_sel) ? pend_err : 1'b0));
    if (pend) check("rdata", rd[pend_sel], pend_rd);
    pend = 1'b0;
  endtask

  task automatic issue(input int s, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    check_pending();
    sel = s; en = 1'b1; wen = w; addr = a; wdata = d;
    #1;
    check("stall_accept", 32'(st[s]), 32'(wait_of(s) > 0));
    for (int k = 1; k <= wait_of(s); k++) begin
      @(negedge clk);
      check("stall_busy", 32'(st[s]), 32'(k < wait_of(s)));
    end
    pend = 1'b1; pend_sel = s; pend_rd = exp_rd; pend_err = exp_err;
  endtask

  task automatic idle();
    @(negedge clk);
    check_pending();
    en = 1'b0; wen = 4'b0000;
  endtask

  typedef struct {
    int          s;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] m_rd;
    logic        m_err;

    vecs[0]  = '{0, 4'b1111, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{0, 4'b0000, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 4'b0010, 32'h10,        32'h00005500, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{0, 4'b0000, 32'h10,        32'h0,        32'hDEAD55EF, 1'b0};
    vecs[4]  = '{0, 4'b1100, 32'h10,        32'h12340000, 32'hDEAD55EF, 1'b0};
    vecs[5]  = '{0, 4'b0000, 32'h10,        32'h0,        32'h123455EF, 1'b0};
    vecs[6]  = '{0, 4'b1111, 32'h0,         32'hA5A50F0F, 32'h123455EF, 1'b0};
    vecs[7]  = '{0, 4'b0000, 32'h00010000,  32'h0,        32'h0,        1'b1};
    vecs[8]  = '{0, 4'b1111, 32'h00010000,  32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[9]  = '{0, 4'b0000, 32'h0,         32'h0,        32'hA5A50F0F, 1'b0};
    vecs[10] = '{0, 4'b1111, 32'h24,        32'h11111111, 32'hA5A50F0F, 1'b0};
    vecs[11] = '{0, 4'b0000, 32'h24,        32'h0,        32'h11111111, 1'b0};
    vecs[12] = '{2, 4'b1111, 32'h10,        32'h123455EF, 32'h0,        1'b0};
    vecs[13] = '{2, 4'b0000, 32'h10,        32'h0,        32'h123455EF, 1'b0};
    vecs[14] = '{1, 4'b1111, 32'h20,        32'h55AA55AA, 32'h0,        1'b0};

    rst = 1'b1; en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0; sel = 0;
    for (int i = 0; i < NDUT; i++) rd_m[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check("reset_rdata", rd[i], 32'h0);
      check("reset_stall", 32'(st[i]), 32'h0);
      check("reset_err",   32'(er[i]), 32'h0);
    end

    // Directed vectors, including back-to-back write/read and out-of-range.
    for (int v = 0; v < 15; v++) begin
      model_access(vecs[v].s, vecs[v].w, vecs[v].a, vecs[v].d, m_rd, m_err);
      issue(vecs[v].s, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].exp_rd, vecs[v].exp_err);
    end
    idle();

    // Reset in the first BUSY cycle of a 2-wait write abandons the write.
    @(negedge clk);
    check_pending();
    sel = 1; en = 1'b1; wen = 4'b1111; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; wen = 4'b0000;
    for (int i = 0; i < NDUT; i++) begin
      check("rst_busy_stall", 32'(st[i]), 32'h0);
      check("rst_busy_rdata", rd[i], 32'h0);
      rd_m[i] = 32'd0;
    end
    model_access(1, 4'b0000, 32'h20, 32'h0, m_rd, m_err);
    issue(1, 4'b0000, 32'h20, 32'h0, 32'h55AA55AA, 1'b0);
    idle();

    // Random traffic against the model over a small preloaded window.
    for (int s = 0; s < NDUT; s++) begin
      for (int i = 0; i < 16; i++) begin
        logic [31:0] d;
        d = $urandom;
        model_access(s, 4'b1111, 32'(i * 4), d, m_rd, m_err);
        issue(s, 4'b1111, 32'(i * 4), d, m_rd, m_err);
      end
    end
    for (int n = 0; n < 120; n++) begin
      int          s;
      logic [3:0]  w;
      logic [31:0] a, d;
      s = int'($urandom_range(0, NDUT - 1));
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(ADDR_W + 2, 31));
      d = $urandom;
      model_access(s, w, a, d, m_rd, m_err);
      issue(s, w, a, d, m_rd, m_err);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
